// File: rtl/fir_interp_poly.sv
// Polyphase FIR interpolator: one input sample in, PHASES filtered samples out (AXI-Stream).
// Define FIR_INTERP_SATURATE_EN to clamp outputs instead of wrapping.
module fir_interp_poly #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEF_WIDTH = 32,
    parameter int unsigned TAPS       = 4,
    parameter int unsigned PHASES     = 2,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [COEF_WIDTH*TAPS*PHASES-1:0]   coef_flat,
    output logic [OUT_WIDTH-1:0]                m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast
);

    localparam int unsigned ProdWidth = DATA_WIDTH + COEF_WIDTH;
    localparam int unsigned AccWidth  = ProdWidth + $clog2(TAPS);
    localparam int unsigned PhW       = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PhW-1:0] LastPhase = PhW'(PHASES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

    state_e                        state_q;
    logic signed [DATA_WIDTH-1:0]  x_q [TAPS];
    logic [PhW-1:0]                phase_q;

    logic signed [COEF_WIDTH-1:0]  coef [PHASES][TAPS];
    logic signed [AccWidth-1:0]    acc;
    logic signed [AccWidth-1:0]    shifted;
    logic [OUT_WIDTH-1:0]          out_d;

    for (genvar p = 0; p < PHASES; p++) begin : g_phase
        for (genvar k = 0; k < TAPS; k++) begin : g_tap
            assign coef[p][k] = coef_flat[(p*TAPS+k)*COEF_WIDTH +: COEF_WIDTH];
        end
    end

    always_comb begin
        logic signed [ProdWidth-1:0] prod;
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod = x_q[k] * coef[phase_q][k];
            acc  = acc + AccWidth'(prod);
        end
        shifted = acc >>> SHIFT;
    end

`ifdef FIR_INTERP_SATURATE_EN
    localparam logic signed [AccWidth-1:0] OutMax =
        {{(AccWidth-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] OutMin =
        {{(AccWidth-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        if (shifted > OutMax) begin
            out_d = OutMax[OUT_WIDTH-1:0];
        end else if (shifted < OutMin) begin
            out_d = OutMin[OUT_WIDTH-1:0];
        end else begin
            out_d = shifted[OUT_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        out_d = shifted[OUT_WIDTH-1:0];
    end
`endif

    assign s_axis_tready = (state_q == StIdle);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (s_axis_tvalid) begin
                        x_q[0] <= s_axis_tdata;
                        for (int k = 1; k < TAPS; k++) begin
                            x_q[k] <= x_q[k-1];
                        end
                        phase_q <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    m_axis_tdata  <= out_d;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= (phase_q == LastPhase);
                    state_q       <= StEmit;
                end
                StEmit: begin
                    // tdata/tlast are left untouched so they stay stable across a stall.
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        if (phase_q != LastPhase) begin
                            phase_q <= phase_q + 1'b1;
                            state_q <= StLoad;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
